// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial sequence detector.
// Build option: SEQ_DET_COUNT_EN adds the saturating match counter.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);
  localparam int MIN_LEN     = 2;
  localparam int CNT_W       = 16;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter with enable and synchronous clear.
// Only instantiated when SEQ_DET_COUNT_EN is defined.
module seq_det_match_cnt
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/seq_det_param.sv
// Runtime-configurable serial pattern detector with Mealy and Moore match flags.
// Build option: SEQ_DET_COUNT_EN adds the match_cnt output.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int                  MAX_LEN     = DEF_MAX_LEN,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(8'b0000_0101),
  parameter int                  DEF_LEN     = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           x,
  input  logic                           x_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  output logic                           y_mealy,
  output logic                           y_moore
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]               match_cnt
`endif
);

  localparam int LW = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] hist_reg, hist_next;
  logic [MAX_LEN-1:0] pattern_reg;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      fill_reg, fill_next;
  logic [LW-1:0]      len_reg;
  logic [LW-1:0]      cfg_len_clamped;
  ovl_mode_e          overlap_reg;
  logic               y_moore_reg;
  logic               accept;
  logic               match;

  always_comb begin
    cfg_len_clamped = cfg_len;
    if (cfg_len < LW'(MIN_LEN)) begin
      cfg_len_clamped = LW'(MIN_LEN);
    end else if (cfg_len > LW'(MAX_LEN)) begin
      cfg_len_clamped = LW'(MAX_LEN);
    end
  end

  // Only the low len bits of history take part in the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (LW'(gi) < len_reg);
  end

  always_comb begin
    accept    = x_valid & ~cfg_load;
    hist_next = {hist_reg[MAX_LEN-2:0], x};
    fill_next = (fill_reg >= len_reg) ? len_reg : fill_reg + LW'(1);
    match     = accept && (fill_next == len_reg) &&
                (((hist_next ^ pattern_reg) & len_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      pattern_reg <= DEF_PATTERN;
      len_reg     <= LW'(DEF_LEN);
      overlap_reg <= OVL_ON;
      y_moore_reg <= 1'b0;
    end else if (cfg_load) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      pattern_reg <= cfg_pattern;
      len_reg     <= cfg_len_clamped;
      overlap_reg <= ovl_mode_e'(cfg_overlap);
      y_moore_reg <= 1'b0;
    end else begin
      y_moore_reg <= match;
      if (accept) begin
        hist_reg <= hist_next;
        // Non-overlapping mode restarts the history after every match.
        fill_reg <= (match && (overlap_reg == OVL_OFF)) ? '0 : fill_next;
      end
    end
  end

  assign y_mealy = match;
  assign y_moore = y_moore_reg;

`ifdef SEQ_DET_COUNT_EN
  seq_det_match_cnt u_match_cnt (
    .clk   (clk),
    .srst  (reset),
    .clear (cfg_load),
    .en    (match),
    .cnt   (match_cnt)
  );
`endif

endmodule
